lathe_cycle_sequencer: RTL and testbench

- Sequences one automatic turning cycle on the retrofitted manual lathe: spindle spin-up, feed to end limit, dwell, retract to home, then part count.
- Adds interlocks (e-stop, door), move timeouts with fault latching, a manual jog path and batch counting.
- Sits between the operator panel / limit-switch inputs and the spindle, feed and coolant drivers. Supersedes the simple start/stop latch + delay + counter logic.

---
 rtl/lathe_pkg.sv | 25 ++
 rtl/lathe_seq_timer.sv | 32 +++
 rtl/lathe_cycle_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_lathe_cycle_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lathe_pkg.sv
// Shared encodings and default 50 MHz timing for the lathe cycle sequencer.
package lathe_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPIN_UP  = 3'd1,
    FEED     = 3'd2,
    DWELL    = 3'd3,
    RETRACT  = 3'd4,
    COMPLETE = 3'd5,
    FAULT    = 3'd6
  } state_t;

  localparam logic [1:0] FC_NONE       = 2'd0;
  localparam logic [1:0] FC_INTERLOCK  = 2'd1;
  localparam logic [1:0] FC_FEED_TO    = 2'd2;
  localparam logic [1:0] FC_RETRACT_TO = 2'd3;

  localparam int DEF_SPINUP_CYCLES = 150_000_000;
  localparam int DEF_DWELL_CYCLES  = 50_000_000;
  localparam int DEF_MOVE_TIMEOUT  = 500_000_000;
  localparam int DEF_BATCH_SIZE    = 5;
  localparam int DEF_TMR_W         = 29;

endpackage

// File: rtl/lathe_seq_timer.sv
// Per-state cycle timer: restarts on every state change, flags the spin-up and dwell terminal counts.
module lathe_seq_timer #(
  parameter int TMR_W         = 29,
  parameter int SPINUP_CYCLES = 150_000_000,
  parameter int DWELL_CYCLES  = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [TMR_W-1:0] count,
  output logic             spinup_end,
  output logic             dwell_end
);

  // cycle counter, zeroed on the edge that enters a new state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {TMR_W{1'b0}};
    end else if (clr) begin
      count <= {TMR_W{1'b0}};
    end else if (en) begin
      count <= count + {{(TMR_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign spinup_end = (count == TMR_W'(SPINUP_CYCLES - 1));
  assign dwell_end  = (count == TMR_W'(DWELL_CYCLES - 1));

endmodule

// File: rtl/lathe_cycle_sequencer.sv
// Automatic turning-cycle sequencer with interlocks, move timeouts, manual jog and batch counting.
module lathe_cycle_sequencer
  import lathe_pkg::*;
#(
  parameter int SPINUP_CYCLES = DEF_SPINUP_CYCLES,
  parameter int DWELL_CYCLES  = DEF_DWELL_CYCLES,
  parameter int MOVE_TIMEOUT  = DEF_MOVE_TIMEOUT,
  parameter int BATCH_SIZE    = DEF_BATCH_SIZE,
  parameter int TMR_W         = DEF_TMR_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       estop,
  input  logic       door_closed,
  input  logic       AUTO,
  input  logic       MAN,
  input  logic       jog_fwd,
  input  logic       jog_rev,
  input  logic       limit_home,
  input  logic       limit_end,
  input  logic       count_clr,
  input  logic       fault_clr,
  output logic       spindle_en,
  output logic       feed_fwd,
  output logic       feed_rev,
  output logic       coolant_en,
  output logic       cycle_done,
  output logic       batch_done,
  output logic [7:0] part_count,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state
);

  state_t           state_r;
  state_t           next_state_s;
  logic [1:0]       next_code_s;
  logic             stopped_r;
  logic             stop_set_s;
  logic [TMR_W-1:0] tmr_count_s;
  logic             spinup_end_s;
  logic             dwell_end_s;
  logic             move_end_s;
  logic             trip_s;
  logic             stop_req_s;
  logic             man_ok_s;
  logic [7:0]       count_next_s;
  logic             spindle_s;
  logic             coolant_s;
  logic             fwd_s;
  logic             rev_s;

  lathe_seq_timer #(
    .TMR_W        (TMR_W),
    .SPINUP_CYCLES(SPINUP_CYCLES),
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (next_state_s != state_r),
    .en        (1'b1),
    .count     (tmr_count_s),
    .spinup_end(spinup_end_s),
    .dwell_end (dwell_end_s)
  );

  assign move_end_s = (tmr_count_s == TMR_W'(MOVE_TIMEOUT - 1));
  assign trip_s     = estop | ~door_closed;
  // leaving auto mid-cycle is treated exactly like the stop button
  assign stop_req_s = stop | ~AUTO;
  assign state      = state_r;

  // next-state selection; interlock trip overrides every other transition
  always_comb begin
    next_state_s = state_r;
    next_code_s  = fault_code;
    stop_set_s   = 1'b0;
    if ((state_r != IDLE) && (state_r != FAULT) && trip_s) begin
      next_state_s = FAULT;
      next_code_s  = FC_INTERLOCK;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && AUTO && !trip_s && limit_home && !batch_done && !count_clr) next_state_s = SPIN_UP;
          else next_state_s = IDLE;
        end
        SPIN_UP: begin
          if (stop_req_s) next_state_s = IDLE;
          else if (spinup_end_s) next_state_s = FEED;
          else next_state_s = SPIN_UP;
        end
        FEED: begin
          if (stop_req_s) begin
            next_state_s = RETRACT;
            stop_set_s   = 1'b1;
          end else if (limit_end) begin
            next_state_s = DWELL;
          end else if (move_end_s) begin
            next_state_s = FAULT;
            next_code_s  = FC_FEED_TO;
          end else begin
            next_state_s = FEED;
          end
        end
        DWELL: begin
          if (stop_req_s) begin
            next_state_s = RETRACT;
            stop_set_s   = 1'b1;
          end else if (dwell_end_s) begin
            next_state_s = RETRACT;
          end else begin
            next_state_s = DWELL;
          end
        end
        RETRACT: begin
          if (limit_home) begin
            next_state_s = stopped_r ? IDLE : COMPLETE;
          end else if (move_end_s) begin
            next_state_s = FAULT;
            next_code_s  = FC_RETRACT_TO;
          end else begin
            next_state_s = RETRACT;
          end
        end
        COMPLETE: next_state_s = IDLE;
        FAULT: begin
          if (fault_clr && !trip_s) begin
            next_state_s = IDLE;
            next_code_s  = FC_NONE;
          end else begin
            next_state_s = FAULT;
          end
        end
        default: begin
          next_state_s = IDLE;
          next_code_s  = FC_NONE;
        end
      endcase
    end
  end

  // part counter update: clear only when idle/faulted, saturating increment on entry to COMPLETE
  always_comb begin
    count_next_s = part_count;
    if (count_clr && ((state_r == IDLE) || (state_r == FAULT))) begin
      count_next_s = 8'd0;
    end else if ((next_state_s == COMPLETE) && (part_count < 8'(BATCH_SIZE))) begin
      count_next_s = part_count + 8'd1;
    end else begin
      count_next_s = part_count;
    end
  end

  // drive decode from the next state so outputs move on the same edge as the state
  always_comb begin
    spindle_s = 1'b0;
    coolant_s = 1'b0;
    fwd_s     = 1'b0;
    rev_s     = 1'b0;
    man_ok_s  = MAN & ~AUTO & ~trip_s;
    case (next_state_s)
      SPIN_UP: spindle_s = 1'b1;
      FEED: begin
        spindle_s = 1'b1;
        coolant_s = 1'b1;
        fwd_s     = 1'b1;
      end
      DWELL: begin
        spindle_s = 1'b1;
        coolant_s = 1'b1;
      end
      RETRACT: begin
        spindle_s = 1'b1;
        rev_s     = 1'b1;
      end
      IDLE: begin
        if (man_ok_s) begin
          spindle_s = start;
          fwd_s     = jog_fwd & ~jog_rev & ~limit_end;
          rev_s     = jog_rev & ~jog_fwd & ~limit_home;
        end else begin
          spindle_s = 1'b0;
          fwd_s     = 1'b0;
          rev_s     = 1'b0;
        end
      end
      default: begin
        spindle_s = 1'b0;
        coolant_s = 1'b0;
        fwd_s     = 1'b0;
        rev_s     = 1'b0;
      end
    endcase
  end

  // state, stopped-cycle flag, counter and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      stopped_r  <= 1'b0;
      part_count <= 8'd0;
      batch_done <= 1'b0;
      fault_code <= FC_NONE;
      fault      <= 1'b0;
      cycle_done <= 1'b0;
      spindle_en <= 1'b0;
      coolant_en <= 1'b0;
      feed_fwd   <= 1'b0;
      feed_rev   <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      if (next_state_s == SPIN_UP) stopped_r <= 1'b0;
      else if (stop_set_s) stopped_r <= 1'b1;
      else stopped_r <= stopped_r;
      part_count <= count_next_s;
      batch_done <= (count_next_s == 8'(BATCH_SIZE));
      fault_code <= next_code_s;
      fault      <= (next_state_s == FAULT);
      cycle_done <= (next_state_s == COMPLETE);
      spindle_en <= spindle_s;
      coolant_en <= coolant_s;
      feed_fwd   <= fwd_s;
      feed_rev   <= rev_s;
    end
  end

endmodule

// File: tb/tb_lathe_cycle_sequencer.sv
// Directed test-plan scenarios plus randomized panel/limit stimulus, checked cycle by cycle against a behavioural model.
module tb_lathe_cycle_sequencer;

  localparam int SPIN = 4;
  localparam int DW   = 3;
  localparam int TO   = 20;
  localparam int B    = 2;

  logic clk = 1'b0;
  logic rst;
  logic start, stop, estop, door_closed, AUTO, MAN, jog_fwd, jog_rev;
  logic limit_home, limit_end, count_clr, fault_clr;
  logic spindle_en, feed_fwd, feed_rev, coolant_en, cycle_done, batch_done, fault;
  logic [7:0] part_count;
  logic [1:0] fault_code;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // reference model: phase number, cycles spent in it, parts made
  int m_state, m_age, m_count, m_code;
  bit m_stopped;
  bit e_spin, e_cool, e_fwd, e_rev;

  lathe_cycle_sequencer #(
    .SPINUP_CYCLES(SPIN), .DWELL_CYCLES(DW), .MOVE_TIMEOUT(TO), .BATCH_SIZE(B), .TMR_W(29)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .estop(estop), .door_closed(door_closed),
    .AUTO(AUTO), .MAN(MAN), .jog_fwd(jog_fwd), .jog_rev(jog_rev), .limit_home(limit_home),
    .limit_end(limit_end), .count_clr(count_clr), .fault_clr(fault_clr),
    .spindle_en(spindle_en), .feed_fwd(feed_fwd), .feed_rev(feed_rev), .coolant_en(coolant_en),
    .cycle_done(cycle_done), .batch_done(batch_done), .part_count(part_count),
    .fault(fault), .fault_code(fault_code), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  nxt;
    bit  trip, sreq, man_ok;
    trip = estop || !door_closed;
    sreq = stop || !AUTO;
    nxt  = m_state;
    if (m_state != 0 && m_state != 6 && trip) begin
      nxt = 6; m_code = 1;
    end else if (m_state == 0) begin
      if (start && AUTO && !trip && limit_home && m_count != B && !count_clr) nxt = 1;
    end else if (m_state == 1) begin
      if (sreq) nxt = 0;
      else if (m_age == SPIN - 1) nxt = 2;
    end else if (m_state == 2) begin
      if (sreq) begin nxt = 4; m_stopped = 1; end
      else if (limit_end) nxt = 3;
      else if (m_age == TO - 1) begin nxt = 6; m_code = 2; end
    end else if (m_state == 3) begin
      if (sreq) begin nxt = 4; m_stopped = 1; end
      else if (m_age == DW - 1) nxt = 4;
    end else if (m_state == 4) begin
      if (limit_home) nxt = m_stopped ? 0 : 5;
      else if (m_age == TO - 1) begin nxt = 6; m_code = 3; end
    end else if (m_state == 6) begin
      if (fault_clr && !trip) begin nxt = 0; m_code = 0; end
    end else begin
      nxt = 0;
    end
    if ((m_state == 0 || m_state == 6) && count_clr) m_count = 0;
    if (nxt == 5 && m_count < B) m_count++;
    m_age = (nxt == m_state) ? m_age + 1 : 0;
    if (nxt == 1) m_stopped = 0;
    m_state = nxt;
    man_ok = MAN && !AUTO && !trip && nxt == 0;
    e_spin = (nxt >= 1 && nxt <= 4) || (man_ok && start);
    e_cool = (nxt == 2 || nxt == 3);
    e_fwd  = (nxt == 2) || (man_ok && jog_fwd && !jog_rev && !limit_end);
    e_rev  = (nxt == 4) || (man_ok && jog_rev && !jog_fwd && !limit_home);
  endtask

  task automatic check_outputs();
    check_eq("state", int'(state), m_state);
    check_eq("spindle_en", int'(spindle_en), int'(e_spin));
    check_eq("coolant_en", int'(coolant_en), int'(e_cool));
    check_eq("feed_fwd", int'(feed_fwd), int'(e_fwd));
    check_eq("feed_rev", int'(feed_rev), int'(e_rev));
    check_eq("cycle_done", int'(cycle_done), int'(m_state == 5));
    check_eq("part_count", int'(part_count), m_count);
    check_eq("batch_done", int'(batch_done), int'(m_count == B));
    check_eq("fault", int'(fault), int'(m_state == 6));
    check_eq("fault_code", int'(fault_code), m_code);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; estop = 1'b0; door_closed = 1'b1; AUTO = 1'b1; MAN = 1'b0;
    jog_fwd = 1'b0; jog_rev = 1'b0; limit_home = 1'b1; limit_end = 1'b0;
    count_clr = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic to_feed();
    idle_inputs();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (SPIN) cycle();
    limit_home = 1'b0;
  endtask

  task automatic nominal(input int exp_count);
    to_feed();
    check_eq("nom_feed", int'(state), 2);
    repeat (2) cycle();
    limit_end = 1'b1;
    cycle();
    check_eq("nom_dwell", int'(state), 3);
    limit_end = 1'b0;
    repeat (DW) cycle();
    check_eq("nom_retract", int'(state), 4);
    check_eq("nom_retract_rev", int'(feed_rev), 1);
    limit_home = 1'b1;
    cycle();
    check_eq("nom_complete", int'(state), 5);
    check_eq("nom_cycle_done", int'(cycle_done), 1);
    check_eq("nom_count", int'(part_count), exp_count);
    cycle();
    check_eq("nom_idle", int'(state), 0);
    check_eq("nom_done_low", int'(cycle_done), 0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_state = 0; m_age = 0; m_count = 0; m_code = 0; m_stopped = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_count", int'(part_count), 0);
    check_eq("rst_drives", int'({spindle_en, feed_fwd, feed_rev, coolant_en, cycle_done, batch_done, fault}), 0);
    check_eq("rst_code", int'(fault_code), 0);
    rst = 1'b0;

    nominal(1);
    nominal(2);
    check_eq("batch_done", int'(batch_done), 1);
    start = 1'b1;
    repeat (2) cycle();
    check_eq("batch_blocks_start", int'(state), 0);
    start = 1'b1; count_clr = 1'b1;
    cycle();
    check_eq("clr_count", int'(part_count), 0);
    check_eq("clr_batch", int'(batch_done), 0);
    check_eq("clr_beats_start", int'(state), 0);

    // estop in dwell
    to_feed();
    limit_end = 1'b1;
    cycle();
    limit_end = 1'b0;
    estop = 1'b1;
    cycle();
    check_eq("estop_state", int'(state), 6);
    check_eq("estop_code", int'(fault_code), 1);
    check_eq("estop_drives", int'({spindle_en, coolant_en, feed_fwd, feed_rev}), 0);
    fault_clr = 1'b1;
    cycle();
    check_eq("estop_held", int'(state), 6);
    estop = 1'b0;
    cycle();
    check_eq("estop_exit", int'(state), 0);
    check_eq("estop_code_clr", int'(fault_code), 0);

    // feed timeout
    to_feed();
    repeat (TO - 1) cycle();
    check_eq("feed_to_hold", int'(state), 2);
    cycle();
    check_eq("feed_to_state", int'(state), 6);
    check_eq("feed_to_code", int'(fault_code), 2);
    fault_clr = 1'b1;
    cycle();

    // stop during feed
    to_feed();
    cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check_eq("stop_retract", int'(state), 4);
    check_eq("stop_rev", int'(feed_rev), 1);
    limit_home = 1'b1;
    cycle();
    check_eq("stop_idle", int'(state), 0);
    check_eq("stop_no_done", int'(cycle_done), 0);
    check_eq("stop_count", int'(part_count), 0);

    // manual jog
    idle_inputs();
    AUTO = 1'b0; MAN = 1'b1; limit_home = 1'b0; jog_fwd = 1'b1;
    cycle();
    check_eq("man_fwd", int'(feed_fwd), 1);
    limit_end = 1'b1;
    cycle();
    check_eq("man_fwd_limit", int'(feed_fwd), 0);
    limit_end = 1'b0; jog_rev = 1'b1;
    cycle();
    check_eq("man_both", int'({feed_fwd, feed_rev}), 0);

    // randomized operation
    for (int i = 0; i < 4000; i++) begin
      start       = ($urandom % 3) == 0;
      stop        = ($urandom % 40) == 0;
      estop       = ($urandom % 80) == 0;
      door_closed = ($urandom % 60) != 0;
      AUTO        = ($urandom % 12) != 0;
      MAN         = ($urandom % 2) == 0;
      jog_fwd     = ($urandom % 2) == 0;
      jog_rev     = ($urandom % 2) == 0;
      limit_home  = ($urandom % 3) == 0;
      limit_end   = ($urandom % 6) == 0;
      count_clr   = ($urandom % 25) == 0;
      fault_clr   = ($urandom % 4) == 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
